// File: rtl/radix4_booth_seq_param.sv
// Sequential radix-4 Booth multiplier that retires one digit per clock.
// Each transaction selects signed or unsigned operands, with valid/ready handshakes on both sides.
module radix4_booth_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // CALC  | adding one Booth partial product per cycle
  // DONE  | product held on result until out_ready

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int MW   = WIDTH + 3;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("radix4_booth_seq_param: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] mcand;
  logic [AW-1:0] acc;
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_next;
  logic [AW-1:0] mcand_x2;
  logic [MW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_dig;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last_dig = (state == CALC) && (cnt == LAST_DIG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt == LAST_DIG) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Negation happens at the full accumulator width, so -2*min_signed stays exact.
  assign mcand_x2 = {mcand[AW-2:0], 1'b0};

  always_comb begin
    pp = '0;
    case (mplier[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand_x2;
      3'b100:         pp = -mcand_x2;
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  assign acc_next = acc + pp;

  // Multiplicand walks left and multiplier walks right, so digit i is always mplier[2:0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= {{(WIDTH+2){is_signed & a[WIDTH-1]}}, a};
            mplier <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= {mcand[AW-3:0], 2'b00};
          mplier <= {2'b00, mplier[MW-1:2]};
          cnt    <= cnt + CW'(1);
          if (last_dig) begin
            result    <= acc_next[2*WIDTH-1:0];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_booth_seq_param.sv
// Bench for the sequential Booth multiplier: WIDTH=32 and WIDTH=8 instances checked against plain-arithmetic products.
module tb_radix4_booth_seq_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        in_valid32 = 1'b0, in_ready32, s32 = 1'b0, out_valid32, out_ready32 = 1'b0, busy32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] result32;

  logic        in_valid8 = 1'b0, in_ready8, s8 = 1'b0, out_valid8, out_ready8 = 1'b0, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] result8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  radix4_booth_seq_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .is_signed(s32), .out_valid(out_valid32),
    .out_ready(out_ready32), .result(result32), .busy(busy32));

  radix4_booth_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(s8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .busy(busy8));

  typedef struct {
    bit        w8;
    bit [31:0] a;
    bit [31:0] b;
    bit        s;
    bit [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: the product computed directly with wide integer arithmetic.
  function automatic logic [63:0] ref_mul(input bit w8, input logic [31:0] x, input logic [31:0] y, input bit sg);
    longint p;
    logic [7:0] x8, y8;
    x8 = x[7:0];
    y8 = y[7:0];
    if (w8) begin
      if (sg) p = longint'($signed(x8)) * longint'($signed(y8));
      else    p = longint'({56'b0, x8}) * longint'({56'b0, y8});
      return {48'b0, p[15:0]};
    end
    if (sg) p = longint'($signed(x)) * longint'($signed(y));
    else    p = longint'({32'b0, x}) * longint'({32'b0, y});
    return p;
  endfunction

  function automatic logic [31:0] pick(input bit w8);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = w8 ? 32'h80 : 32'h8000_0000;
      3:       v = 32'h1;
      default: v = $urandom;
    endcase
    return w8 ? {24'b0, v[7:0]} : v;
  endfunction

  task automatic do_op(input bit w8, input logic [31:0] oa, input logic [31:0] ob, input bit os,
                       output logic [63:0] r, output int lat);
    int g;
    g = 0;
    while (!(w8 ? in_ready8 : in_ready32) && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 200) timeout("in_ready_wait");
    @(negedge clk);
    if (w8) begin a8 = oa[7:0]; b8 = ob[7:0]; s8 = os; in_valid8 = 1'b1; end
    else    begin a32 = oa; b32 = ob; s32 = os; in_valid32 = 1'b1; end
    @(posedge clk); #1;
    in_valid8  = 1'b0;
    in_valid32 = 1'b0;
    lat = 0;
    while (!(w8 ? out_valid8 : out_valid32) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 100) timeout("out_valid_wait");
    r = w8 ? {48'b0, result8} : result32;
    @(negedge clk);
    if (w8) out_ready8 = 1'b1; else out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready8  = 1'b0;
    out_ready32 = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [63:0] r, exp;
    int          lat, g;
    logic [31:0] ra, rb;
    bit          rs;

    vecs.push_back('{1'b0, 32'd7,         32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});
    vecs.push_back('{1'b0, 32'd0,         32'hDEAD_BEEF, 1'b1, 64'h0});
    vecs.push_back('{1'b1, 32'hFF,        32'hFF,        1'b0, 64'hFE01});
    vecs.push_back('{1'b1, 32'h80,        32'h80,        1'b1, 64'h4000});
    vecs.push_back('{1'b1, 32'h7F,        32'h80,        1'b1, 64'hC080});
    vecs.push_back('{1'b1, 32'hFF,        32'h02,        1'b1, 64'hFFFE});

    #12;
    check("reset_in_ready32", in_ready32, 1);
    check("reset_out_valid32", out_valid32, 0);
    check("reset_busy32", busy32, 0);
    check("reset_result32", result32, 0);
    check("reset_result8", {48'b0, result8}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].w8, vecs[i].a, vecs[i].b, vecs[i].s, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].w8 ? 64'd5 : 64'd17);
    end

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    exp = ref_mul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    @(negedge clk);
    a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; s32 = 1'b1; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    a32 = 32'h5; b32 = 32'h5;
    g = 0;
    while (!out_valid32 && g < 100) begin @(posedge clk); #1; g++; end
    if (g >= 100) timeout("bp_out_valid_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid32 = (i == 3);
      @(posedge clk); #1;
      check("bp_result", result32, exp);
      check("bp_out_valid", out_valid32, 1);
      check("bp_in_ready", in_ready32, 0);
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check("bp_release_in_ready", in_ready32, 1);
    check("bp_release_out_valid", out_valid32, 0);
    check("bp_release_busy", busy32, 0);
    @(posedge clk); #1;
    check("bp_stray_not_captured", busy32, 0);

    // Reset asserted mid-calculation aborts the operation immediately.
    @(negedge clk);
    a32 = 32'hFFFF_0001; b32 = 32'h7654_3210; s32 = 1'b0; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid32, 0);
    check("midrst_in_ready", in_ready32, 1);
    check("midrst_busy", busy32, 0);
    check("midrst_result", result32, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1 check("midrst_no_output", out_valid32, 0);
    do_op(1'b0, 32'd12, 32'd10, 1'b0, r, lat);
    check("midrst_next_op", r, 64'd120);

    for (int i = 0; i < 2500; i++) begin
      ra = pick(1'b1); rb = pick(1'b1); rs = $urandom_range(0, 1);
      do_op(1'b1, ra, rb, rs, r, lat);
      check($sformatf("rand8 %h*%h s=%0d", ra[7:0], rb[7:0], rs), r, ref_mul(1'b1, ra, rb, rs));
    end
    for (int i = 0; i < 1500; i++) begin
      ra = pick(1'b0); rb = pick(1'b0); rs = $urandom_range(0, 1);
      do_op(1'b0, ra, rb, rs, r, lat);
      check($sformatf("rand32 %h*%h s=%0d", ra, rb, rs), r, ref_mul(1'b0, ra, rb, rs));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
